spi_reg_peripheral: RTL

- SPI target (mode 0, write-focused) that decodes 16-bit frames from ui_in pins and holds the five control registers consumed by pwm_peripheral: en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle.
- Sits directly upstream of pwm_peripheral in the top level. Its register outputs wire straight to the PWM block's inputs.
- Asynchronous SPI pins are synchronized into clk. Registers are only committed on a complete, valid transaction.

---
 rtl/spi_reg_pkg.sv | 28 ++
 rtl/spi_reg_peripheral_if.sv | 10 +
 rtl/spi_reg_peripheral_sync_edge.sv | 47 ++++
 rtl/spi_reg_peripheral.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register target: frame geometry, register
// address map and the frame-decoder FSM state encoding.
package spi_reg_pkg;

  localparam int FRAME_W  = 16;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 7;
  localparam int NUM_REGS = 5;

  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_PWM_DUTY    = 7'h04;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  // True when an address falls inside the writable register window.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                         input logic [ADDR_W-1:0] max_addr);
    return (addr <= max_addr);
  endfunction

endpackage

// File: rtl/spi_reg_peripheral_if.sv
// SPI pin bundle between a controller (master) and the register target (slave).
interface spi_reg_peripheral_if;
  logic ncs;
  logic sclk;
  logic copi;
  logic cipo;

  modport master (output ncs, output sclk, output copi, input cipo);
  modport slave  (input ncs, input sclk, input copi, output cipo);
endinterface

// File: rtl/spi_reg_peripheral_sync_edge.sv
// Pin synchronizer with rise/fall detection. The chain and history flop reset
// to RST_VAL; edges are masked until the chain has been refilled with real
// pin samples, so a pin that differs from RST_VAL at reset release never
// produces an edge.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int FILL_MAX = SYNC_STAGES + 1;
  localparam int FILL_W   = $clog2(FILL_MAX + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic [FILL_W-1:0]      fill_q;
  logic                   filled_s;

  // Shift the pin through the synchronizer chain and keep one history sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      hist_q <= RST_VAL;
      fill_q <= FILL_W'(0);
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      hist_q <= sync_q[SYNC_STAGES-1];
      if (fill_q != FILL_W'(FILL_MAX)) begin
        fill_q <= fill_q + FILL_W'(1);
      end else begin
        fill_q <= fill_q;
      end
    end
  end

  assign filled_s = (fill_q == FILL_W'(FILL_MAX));
  assign level_o  = sync_q[SYNC_STAGES-1];
  assign rise_o   = filled_s &  sync_q[SYNC_STAGES-1] & ~hist_q;
  assign fall_o   = filled_s & ~sync_q[SYNC_STAGES-1] &  hist_q;

endmodule

// File: rtl/spi_reg_peripheral.sv
// SPI mode-0 register target feeding pwm_peripheral. Decodes 16-bit frames
// {R/W, addr[6:0], data[7:0]} and commits writes only after a complete frame.
// Optional macro SPI_READBACK_EN adds register readback on cipo; without it
// cipo is tied low and read frames are simply discarded.
module spi_reg_peripheral
  import spi_reg_pkg::*;
#(
  parameter int              SYNC_STAGES = 2,
  parameter logic [6:0]      MAX_ADDR    = 7'h04
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_reg_peripheral_if.slave  spi,
  output logic [7:0]           en_reg_out_7_0,
  output logic [7:0]           en_reg_out_15_8,
  output logic [7:0]           en_reg_pwm_7_0,
  output logic [7:0]           en_reg_pwm_15_8,
  output logic [7:0]           pwm_duty_cycle
);

  localparam logic [4:0] FULL_CNT = 5'(FRAME_W);

  logic ncs_lvl_s,  ncs_rise_s,  ncs_fall_s;
  logic sclk_lvl_s, sclk_rise_s, sclk_fall_s;
  logic copi_lvl_s, copi_rise_s, copi_fall_s;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst(rst), .pin_i(spi.ncs),
    .level_o(ncs_lvl_s), .rise_o(ncs_rise_s), .fall_o(ncs_fall_s)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .pin_i(spi.sclk),
    .level_o(sclk_lvl_s), .rise_o(sclk_rise_s), .fall_o(sclk_fall_s)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst(rst), .pin_i(spi.copi),
    .level_o(copi_lvl_s), .rise_o(copi_rise_s), .fall_o(copi_fall_s)
  );

  state_e              state_q;
  logic [FRAME_W-1:0]  shift_q, shift_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic                frame_ok_s;
  logic [2:0]          wr_idx_s;

  // Shift datapath: take one copi bit per sclk rise until the frame is full.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (sclk_rise_s && (cnt_q < FULL_CNT)) begin
      shift_d = {shift_q[FRAME_W-2:0], copi_lvl_s};
      cnt_d   = cnt_q + 5'd1;
    end else begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
    end
  end

  assign frame_ok_s = (cnt_q == FULL_CNT) && shift_q[15] &&
                      addr_in_range(shift_q[14:8], MAX_ADDR);
  assign wr_idx_s   = shift_q[10:8];

  // Frame FSM: open on ncs fall, shift bits, commit once on ncs rise.
  // An ncs rise seen in the same cycle as an sclk rise wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= 5'd0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (ncs_fall_s) begin
            state_q <= SHIFT;
            shift_q <= '0;
            cnt_q   <= 5'd0;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          if (ncs_rise_s) begin
            state_q <= COMMIT;
          end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
          end
        end
        COMMIT: begin
          if (frame_ok_s) begin
            regs_q[wr_idx_s] <= shift_q[7:0];
          end else begin
            regs_q[wr_idx_s] <= regs_q[wr_idx_s];
          end
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign en_reg_out_7_0  = regs_q[ADDR_EN_OUT_7_0[2:0]];
  assign en_reg_out_15_8 = regs_q[ADDR_EN_OUT_15_8[2:0]];
  assign en_reg_pwm_7_0  = regs_q[ADDR_EN_PWM_7_0[2:0]];
  assign en_reg_pwm_15_8 = regs_q[ADDR_EN_PWM_15_8[2:0]];
  assign pwm_duty_cycle  = regs_q[ADDR_PWM_DUTY[2:0]];

`ifdef SPI_READBACK_EN
  logic [DATA_W-1:0] tx_q;
  logic              rd_active_q;
  logic              cipo_q;
  logic [DATA_W-1:0] rd_data_s;

  // Readback mux: in-range address selects its register, anything else reads 0.
  always_comb begin
    rd_data_s = 8'h00;
    if (addr_in_range(shift_d[6:0], MAX_ADDR)) begin
      rd_data_s = regs_q[shift_d[2:0]];
    end else begin
      rd_data_s = 8'h00;
    end
  end

  // Readback shifter: load after the 8th bit of a read, drive MSB first on sclk falls.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q        <= 8'h00;
      rd_active_q <= 1'b0;
      cipo_q      <= 1'b0;
    end else if ((state_q != SHIFT) || ncs_rise_s) begin
      tx_q        <= 8'h00;
      rd_active_q <= 1'b0;
      cipo_q      <= 1'b0;
    end else if (sclk_rise_s && (cnt_q == 5'd7) && !shift_d[7]) begin
      tx_q        <= rd_data_s;
      rd_active_q <= 1'b1;
    end else if (sclk_fall_s && rd_active_q) begin
      cipo_q <= tx_q[7];
      tx_q   <= {tx_q[6:0], 1'b0};
    end else begin
      tx_q        <= tx_q;
      rd_active_q <= rd_active_q;
      cipo_q      <= cipo_q;
    end
  end

  assign spi.cipo = cipo_q;
`else
  assign spi.cipo = 1'b0;
`endif

  logic unused_s;
  assign unused_s = &{1'b0, ncs_lvl_s, sclk_lvl_s, sclk_fall_s,
                      copi_rise_s, copi_fall_s};

endmodule
